// File: rtl/fp16_maxpool_stream.sv
// Streaming 1-D FP16 max-pool: one maximum per WINDOW samples (or fewer on in_last).
// Define MAXPOOL_ARGMAX_EN to add out_index, the 0-based position of the maximum.
module fp16_maxpool_stream #(
  parameter  int WINDOW = 4,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [CNT_W-1:0] out_index
`endif
);

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  // Monotonic unsigned key: -0 folds onto +0, negatives are bit-inverted.
  function automatic logic [15:0] order_key(input logic [15:0] x);
    logic [15:0] z;
    z = (x[14:0] == 15'd0) ? 16'h0000 : x;
    return z[15] ? ~z : (z | 16'h8000);
  endfunction

  // Strictly greater; a NaN never wins, and a NaN incumbent loses to any number.
  function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
    return !is_nan(a) && (is_nan(b) || (order_key(a) > order_key(b)));
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      max_q, max_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             close_possible, take, close;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] out_index_q, out_index_d;
`endif

  assign close_possible = (cnt_q == CNT_W'(WINDOW - 1)) || in_last;
  // Non-closing beats never touch the output register, so they flow while a result waits.
  assign in_ready       = !out_valid_q || out_ready || !close_possible;
  assign take           = in_valid && in_ready;
  assign close          = take && close_possible;

  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
`ifdef MAXPOOL_ARGMAX_EN
    idx_d       = idx_q;
    out_index_d = out_index_q;
`endif
    if (take) begin
      if (cnt_q == '0 || fp16_gt(in_data, max_q)) begin
        max_d = in_data;
`ifdef MAXPOOL_ARGMAX_EN
        idx_d = cnt_q;
`endif
      end
      if (close) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = max_d;
`ifdef MAXPOOL_ARGMAX_EN
        out_index_d = idx_d;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      max_q       <= 16'h0000;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      idx_q       <= '0;
      out_index_q <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MAXPOOL_ARGMAX_EN
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef MAXPOOL_ARGMAX_EN
  assign out_index = out_index_q;
`endif

endmodule
